fu_seq: RTL and testbench
=========================

Name: fu_seq

Overview:
- Parametrised, handshaked successor of the mycpu combinational function unit.
- Executes the same fs_t opcode set at configurable DATA_W and registers results, so one cycle after accept it drives f_out and flags.
- Adds a real iterative shift-add FMUL and uniform Z/N flags.
- Adds optional unsigned saturation with an overflow flag.
- Sits between the register-file read stage and write-back in the mycpu datapath.

Parameters:
- DATA_W, 16: operand/result width, >=4.
- SATURATE, 1: 1 = clamp FINC/FDEC/FADD/FSUB/FMUL results to [0, 2^DATA_W-1]; 0 = wrap modulo 2^DATA_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  operation request.
- ready_out  out  1  block can accept a request this cycle.
- a_in  in  DATA_W  operand A.
- b_in  in  DATA_W  operand B.
- fs_in  in  4  function select, mycpu_pkg fs_t encoding.
- valid_out  out  1  result valid.
- ready_in  in  1  consumer accepts the result.
- f_out  out  DATA_W  registered result.
- z_out  out  1  f_out == 0.
- n_out  out  1  f_out[DATA_W-1].
- v_out  out  1  unsigned overflow/underflow occurred (clamped if SATURATE=1, wrapped if 0).

Behaviour:
- Reset: async on rst_n=0. State=IDLE, valid_out=0, f_out=0, z_out=0, n_out=0, v_out=0, multiplier regs=0. Reset mid-multiply abandons the operation; no result is produced.
- fs encoding:
  - 0 MOVA, 1 FINC, 2 FDEC, 3 FADD, 4 FSUB, 5 FCLR, 6 FAND, 7 FOR.
  - 8 FXOR, 9 FNOT, 10 FMOVB, 11 FSHR (B>>1), 12 FSHL (B<<1), 13 FMUL.
  - 14-15 reserved: f=0, z=1, n=0, v=0.
- Accept: valid_in && ready_out at a rising edge. a_in, b_in and fs_in are sampled only on that edge.
- ready_out = (state==IDLE) || (state==DONE && ready_in). Back-to-back single-cycle ops therefore sustain one op per cycle while ready_in=1.
- FSM states: IDLE, MUL, DONE.
  - IDLE: accept non-FMUL -> compute combinationally, register f/z/n/v -> DONE.
  - IDLE: accept FMUL -> load multiplicand A, multiplier B, acc=0, cnt=0 -> MUL.
  - MUL: each cycle, if mult[0] then acc += mcand<<cnt (2*DATA_W-bit acc); mult>>=1; cnt++. When cnt==DATA_W-1 completes, register result -> DONE. No accept in MUL (ready_out=0).
  - DONE: valid_out=1; f/z/n/v held stable until ready_in=1.
    - ready_in=1 with no new accept -> IDLE, valid_out=0.
    - ready_in=1 with a new accept -> behave as the IDLE accept; valid_out stays 1 for a non-FMUL new result, drops to 0 while in MUL.
- Latency (accept edge to valid_out high): 1 cycle for non-FMUL, DATA_W+1 cycles for FMUL.
- Flags: z_out and n_out are derived from the registered f_out for every opcode, FCLR included (z=1, n=0).
- Arithmetic/width: computed in DATA_W+1 bits; for FMUL, v_out = |acc[2*DATA_W-1:DATA_W].
  - FINC: overflow when A == all-ones. SAT result = all-ones; wrap result = 0.
  - FADD: overflow on carry-out. SAT result = all-ones.
  - FDEC: underflow when A == 0. SAT result = 0; wrap result = all-ones.
  - FSUB: underflow on borrow (A<B). SAT result = 0.
  - FMUL: overflow when the high half is nonzero. SAT result = all-ones; else low half.
  - All other ops: v=0.
- valid_out never drops without ready_in=1, except on reset.

Test Plan:
- Reset with DATA_W=16, SATURATE=1: pulse rst_n low mid-cycle -> all outputs 0 immediately, ready_out=1 after release.
- FADD A=0xFFF0, B=0x0020 -> next cycle valid_out=1, f=0xFFFF, v=1, n=1, z=0. Same with SATURATE=0 -> f=0x0010, v=1.
- FSUB A=5, B=5 -> f=0, z=1, v=0. FDEC A=0 -> f=0x0000, v=1, z=1.
- FMUL A=0x0012, B=0x0034 -> valid_out exactly 17 cycles after accept, f=0x03A8, v=0, ready_out=0 throughout MUL. FMUL A=0x0100, B=0x0100 -> f=0xFFFF, v=1.
- Backpressure: FXOR A=0x00FF, B=0x0F0F with ready_in=0 for 4 cycles -> f=0x0FF0 held stable, ready_out=0. Then ready_in=1 with a queued FSHL B=0x8001 -> next cycle f=0x0002, z=0, valid_out stays 1.
- Reset asserted 5 cycles into FMUL -> valid_out stays 0, state IDLE. A subsequent MOVA A=0 gives f=0, z=1.

Source files
------------

// File: rtl/fu_seq.sv
// fu_seq: handshaked mycpu function unit. Result registered 1 cycle after accept (FMUL: DATA_W+1, shift-add).
// Backpressure: result held in DONE until ready_in; a new op is accepted in the same cycle the old one drains.
module fu_seq #(
    parameter int DATA_W   = 16,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [3:0]        fs_in,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [DATA_W-1:0] f_out,
    output logic              z_out,
    output logic              n_out,
    output logic              v_out
);
    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [DATA_W-1:0] ONES     = {DATA_W{1'b1}};
    localparam logic [DATA_W:0]   ONE_X    = (DATA_W+1)'(1);
    localparam bit                SAT      = (SATURATE != 0);

    localparam logic [3:0] FS_MOVA  = 4'd0;
    localparam logic [3:0] FS_FINC  = 4'd1;
    localparam logic [3:0] FS_FDEC  = 4'd2;
    localparam logic [3:0] FS_FADD  = 4'd3;
    localparam logic [3:0] FS_FSUB  = 4'd4;
    localparam logic [3:0] FS_FAND  = 4'd6;
    localparam logic [3:0] FS_FOR   = 4'd7;
    localparam logic [3:0] FS_FXOR  = 4'd8;
    localparam logic [3:0] FS_FNOT  = 4'd9;
    localparam logic [3:0] FS_FMOVB = 4'd10;
    localparam logic [3:0] FS_FSHR  = 4'd11;
    localparam logic [3:0] FS_FSHL  = 4'd12;
    localparam logic [3:0] FS_FMUL  = 4'd13;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [DATA_W-1:0]     f_q, f_d;
    logic                  z_q, z_d;
    logic                  n_q, n_d;
    logic                  v_q, v_d;
    logic [DATA_W-1:0]     mcand_q, mcand_d;
    logic [DATA_W-1:0]     mult_q, mult_d;
    logic [2*DATA_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  accept;
    logic [DATA_W:0]       inc_x, dec_x, add_x, sub_x;
    logic [DATA_W-1:0]     alu_f;
    logic                  alu_v;
    logic [2*DATA_W-1:0]   partial, acc_step;
    logic                  mul_hi_nz;
    logic [DATA_W-1:0]     mul_f;
    logic                  res_ld;
    logic [DATA_W-1:0]     res_f;
    logic                  res_v;

    assign ready_out = (state_q == S_IDLE) || ((state_q == S_DONE) && ready_in);
    assign accept    = valid_in && ready_out;
    assign valid_out = (state_q == S_DONE);
    assign f_out     = f_q;
    assign z_out     = z_q;
    assign n_out     = n_q;
    assign v_out     = v_q;

    // One extra bit catches carry-out and borrow for the arithmetic ops.
    assign inc_x = {1'b0, a_in} + ONE_X;
    assign dec_x = {1'b0, a_in} - ONE_X;
    assign add_x = {1'b0, a_in} + {1'b0, b_in};
    assign sub_x = {1'b0, a_in} - {1'b0, b_in};

    always_comb begin
        alu_f = '0;
        alu_v = 1'b0;
        case (fs_in)
            FS_MOVA:  alu_f = a_in;
            FS_FINC: begin
                alu_v = inc_x[DATA_W];
                alu_f = (alu_v && SAT) ? ONES : inc_x[DATA_W-1:0];
            end
            FS_FDEC: begin
                alu_v = dec_x[DATA_W];
                alu_f = (alu_v && SAT) ? '0 : dec_x[DATA_W-1:0];
            end
            FS_FADD: begin
                alu_v = add_x[DATA_W];
                alu_f = (alu_v && SAT) ? ONES : add_x[DATA_W-1:0];
            end
            FS_FSUB: begin
                alu_v = sub_x[DATA_W];
                alu_f = (alu_v && SAT) ? '0 : sub_x[DATA_W-1:0];
            end
            FS_FAND:  alu_f = a_in & b_in;
            FS_FOR:   alu_f = a_in | b_in;
            FS_FXOR:  alu_f = a_in ^ b_in;
            FS_FNOT:  alu_f = ~a_in;
            FS_FMOVB: alu_f = b_in;
            FS_FSHR:  alu_f = {1'b0, b_in[DATA_W-1:1]};
            FS_FSHL:  alu_f = {b_in[DATA_W-2:0], 1'b0};
            default:  alu_f = '0;
        endcase
    end

    // One partial product per cycle; the last step's sum is the full product.
    assign partial   = mult_q[0] ? ({{DATA_W{1'b0}}, mcand_q} << cnt_q) : '0;
    assign acc_step  = acc_q + partial;
    assign mul_hi_nz = |acc_step[2*DATA_W-1:DATA_W];
    assign mul_f     = (mul_hi_nz && SAT) ? ONES : acc_step[DATA_W-1:0];

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mult_d  = mult_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_ld  = 1'b0;
        res_f   = alu_f;
        res_v   = alu_v;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE && ready_in) begin
                    state_d = S_IDLE;
                end
                if (accept) begin
                    if (fs_in == FS_FMUL) begin
                        mcand_d = a_in;
                        mult_d  = b_in;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_MUL;
                    end else begin
                        res_ld  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_MUL: begin
                acc_d  = acc_step;
                mult_d = mult_q >> 1;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    res_ld  = 1'b1;
                    res_f   = mul_f;
                    res_v   = mul_hi_nz;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Flags only change when a new result lands, so they always describe f_q.
    always_comb begin
        f_d = f_q;
        z_d = z_q;
        n_d = n_q;
        v_d = v_q;
        if (res_ld) begin
            f_d = res_f;
            z_d = (res_f == '0);
            n_d = res_f[DATA_W-1];
            v_d = res_v;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            f_q     <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            mcand_q <= '0;
            mult_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            z_q     <= z_d;
            n_q     <= n_d;
            v_q     <= v_d;
            mcand_q <= mcand_d;
            mult_q  <= mult_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fu_seq.sv
// Bench for fu_seq: a saturating and a wrapping instance share stimulus; expected results are queued at drive time.
module tb_fu_seq;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid_in = 1'b0;
    logic         ready_in = 1'b1;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic [3:0]   fs_in = '0;

    logic         ready_s, valid_s, z_s, n_s, v_s;
    logic [W-1:0] f_s;
    logic         ready_w, valid_w, z_w, n_w, v_w;
    logic [W-1:0] f_w;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        logic [3:0]   fs;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] f_s;
        logic         v_s;
        logic [W-1:0] f_w;
        logic         v_w;
    } exp_t;

    exp_t sb[$];

    fu_seq #(.DATA_W(W), .SATURATE(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_s),
        .a_in(a_in), .b_in(b_in), .fs_in(fs_in), .valid_out(valid_s), .ready_in(ready_in),
        .f_out(f_s), .z_out(z_s), .n_out(n_s), .v_out(v_s)
    );

    fu_seq #(.DATA_W(W), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_w),
        .a_in(a_in), .b_in(b_in), .fs_in(fs_in), .valid_out(valid_w), .ready_in(ready_in),
        .f_out(f_w), .z_out(z_w), .n_out(n_w), .v_out(v_w)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: returns {v, f}.
    function automatic logic [W:0] model(input logic [3:0] fs, input logic [W-1:0] a, input logic [W-1:0] b, input bit sat);
        longint unsigned r;
        logic [W-1:0]    f;
        logic            v;
        r = 0;
        f = '0;
        v = 1'b0;
        case (fs)
            4'd0:  f = a;
            4'd1:  begin r = a; r = r + 1; v = (r > 65535); f = (v && sat) ? 16'hFFFF : r[15:0]; end
            4'd2:  begin v = (a == 0); f = v ? (sat ? 16'h0000 : 16'hFFFF) : a - 16'd1; end
            4'd3:  begin r = a; r = r + b; v = (r > 65535); f = (v && sat) ? 16'hFFFF : r[15:0]; end
            4'd4:  begin v = (a < b); f = (v && sat) ? 16'h0000 : a - b; end
            4'd6:  f = a & b;
            4'd7:  f = a | b;
            4'd8:  f = a ^ b;
            4'd9:  f = ~a;
            4'd10: f = b;
            4'd11: f = b >> 1;
            4'd12: f = b << 1;
            4'd13: begin r = a; r = r * b; v = (r > 65535); f = (v && sat) ? 16'hFFFF : r[15:0]; end
            default: f = '0;
        endcase
        return {v, f};
    endfunction

    task automatic push_exp(input logic [3:0] fs, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W:0] rs, rw;
        rs = model(fs, a, b, 1'b1);
        rw = model(fs, a, b, 1'b0);
        e.fs = fs; e.a = a; e.b = b;
        e.f_s = rs[W-1:0]; e.v_s = rs[W];
        e.f_w = rw[W-1:0]; e.v_w = rw[W];
        sb.push_back(e);
    endtask

    // Drives one request, returns #1 after the accepting edge with inputs scrambled.
    task automatic send(input logic [3:0] fs, input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok;
        push_exp(fs, a, b);
        fs_in = fs; a_in = a; b_in = b; valid_in = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (ready_s === 1'b1) ok = 1'b1;
        end
        if (ok) begin
            @(posedge clk); #1;
        end else begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout fs=%0d: ready_out=%b, required 1 within 64 cycles", fs, ready_s);
            void'(sb.pop_back());
        end
        valid_in = 1'b0;
        fs_in = 4'($urandom); a_in = 16'($urandom); b_in = 16'($urandom);
    endtask

    // Latency counts the accept cycle as 1; rdy_hi counts ready_out=1 seen while waiting.
    task automatic wait_valid(output int lat, output int rdy_hi);
        lat = 1; rdy_hi = 0;
        while (valid_s !== 1'b1 && lat < 64) begin
            if (ready_s !== 1'b0) rdy_hi++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ready_in = 1'b1; valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (valid_s !== 0 || f_s !== 0 || z_s !== 0 || n_s !== 0 || v_s !== 0) begin
            miscompares++;
            $display("FAIL reset_init: valid=%b f=%h z=%b n=%b v=%b, required all 0", valid_s, f_s, z_s, n_s, v_s);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (ready_s !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: ready_out=%b, required 1", ready_s);
        end
        ready_in = 1'b0;
        send(4'd9, 16'h0000, 16'h0000);
        sb.delete();
        vectors++;
        if (valid_s !== 1'b1 || f_s !== 16'hFFFF || n_s !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_pre: valid=%b f=%h n=%b, required 1 ffff 1", valid_s, f_s, n_s);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (valid_s !== 0 || f_s !== 0 || z_s !== 0 || n_s !== 0 || v_s !== 0 || valid_w !== 0 || f_w !== 0 || z_w !== 0 || n_w !== 0 || v_w !== 0) begin
            miscompares++;
            $display("FAIL reset_async: sat valid=%b f=%h z=%b n=%b v=%b wrap valid=%b f=%h, required all 0",
                     valid_s, f_s, z_s, n_s, v_s, valid_w, f_w);
        end
        @(negedge clk);
        rst_n = 1'b1; ready_in = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (ready_s !== 1'b1 || valid_s !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: ready_out=%b valid=%b, required 1 0", ready_s, valid_s);
        end
    endtask

    task automatic test_arith;
        logic [3:0]   fs_t[19] = '{4'd3, 4'd4, 4'd2, 4'd1, 4'd1, 4'd4, 4'd3, 4'd2, 4'd0, 4'd5,
                                   4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd14, 4'd15};
        logic [W-1:0] a_t[19]  = '{16'hFFF0, 16'h0005, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h0003, 16'h1234, 16'h8000, 16'h8001, 16'hFFFF,
                                   16'hF0F0, 16'hF000, 16'h00FF, 16'h00FF, 16'hAAAA, 16'h1111, 16'h2222, 16'hFFFF, 16'h1234};
        logic [W-1:0] b_t[19]  = '{16'h0020, 16'h0005, 16'h1111, 16'h0000, 16'h0000, 16'h0005, 16'h1111, 16'h0000, 16'h0000, 16'hFFFF,
                                   16'hFF00, 16'h000F, 16'h0F0F, 16'h0000, 16'h5555, 16'h8001, 16'h8001, 16'hFFFF, 16'h5678};
        int lat, rdy_hi;
        exp_t e;
        for (int i = 0; i < 19; i++) begin
            send(fs_t[i], a_t[i], b_t[i]);
            wait_valid(lat, rdy_hi);
            vectors++;
            if (lat != 1) begin
                miscompares++;
                $display("FAIL arith_latency fs=%0d: %0d cycles, required 1", fs_t[i], lat);
            end
            e = sb.pop_front();
            vectors++;
            if (valid_s !== 1'b1 || f_s !== e.f_s || z_s !== (e.f_s == 16'h0) || n_s !== e.f_s[15] || v_s !== e.v_s) begin
                miscompares++;
                $display("FAIL arith_sat fs=%0d a=%h b=%h: f=%h z=%b n=%b v=%b, required f=%h v=%b",
                         e.fs, e.a, e.b, f_s, z_s, n_s, v_s, e.f_s, e.v_s);
            end
            vectors++;
            if (valid_w !== 1'b1 || f_w !== e.f_w || z_w !== (e.f_w == 16'h0) || n_w !== e.f_w[15] || v_w !== e.v_w) begin
                miscompares++;
                $display("FAIL arith_wrap fs=%0d a=%h b=%h: f=%h z=%b n=%b v=%b, required f=%h v=%b",
                         e.fs, e.a, e.b, f_w, z_w, n_w, v_w, e.f_w, e.v_w);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fmul;
        logic [W-1:0] a_t[6] = '{16'h0012, 16'h0100, 16'hFFFF, 16'h00FF, 16'h0000, 16'h8000};
        logic [W-1:0] b_t[6] = '{16'h0034, 16'h0100, 16'hFFFF, 16'h0101, 16'h1234, 16'h0001};
        int lat, rdy_hi;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            ready_in = i[0];
            send(4'd13, a_t[i], b_t[i]);
            wait_valid(lat, rdy_hi);
            vectors++;
            if (lat != W + 1 || rdy_hi != 0) begin
                miscompares++;
                $display("FAIL fmul_timing a=%h b=%h: latency %0d ready_hi %0d, required %0d and 0", a_t[i], b_t[i], lat, rdy_hi, W + 1);
            end
            e = sb.pop_front();
            vectors++;
            if (valid_s !== 1'b1 || f_s !== e.f_s || z_s !== (e.f_s == 16'h0) || n_s !== e.f_s[15] || v_s !== e.v_s) begin
                miscompares++;
                $display("FAIL fmul_sat a=%h b=%h: f=%h z=%b n=%b v=%b, required f=%h v=%b",
                         e.a, e.b, f_s, z_s, n_s, v_s, e.f_s, e.v_s);
            end
            vectors++;
            if (valid_w !== 1'b1 || f_w !== e.f_w || z_w !== (e.f_w == 16'h0) || n_w !== e.f_w[15] || v_w !== e.v_w) begin
                miscompares++;
                $display("FAIL fmul_wrap a=%h b=%h: f=%h z=%b n=%b v=%b, required f=%h v=%b",
                         e.a, e.b, f_w, z_w, n_w, v_w, e.f_w, e.v_w);
            end
            ready_in = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        int lat, rdy_hi;
        exp_t e;
        ready_in = 1'b0;
        send(4'd8, 16'h00FF, 16'h0F0F);
        wait_valid(lat, rdy_hi);
        e = sb.pop_front();
        vectors++;
        if (lat != 1 || f_s !== e.f_s || z_s !== (e.f_s == 16'h0) || n_s !== e.f_s[15] || v_s !== e.v_s) begin
            miscompares++;
            $display("FAIL bp_first: latency %0d f=%h z=%b n=%b v=%b, required 1 f=%h v=%b", lat, f_s, z_s, n_s, v_s, e.f_s, e.v_s);
        end
        push_exp(4'd12, 16'h3C3C, 16'h8001);
        fs_in = 4'd12; a_in = 16'h3C3C; b_in = 16'h8001; valid_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (valid_s !== 1'b1 || f_s !== e.f_s || ready_s !== 1'b0 || f_w !== e.f_w) begin
                miscompares++;
                $display("FAIL bp_hold cycle %0d: valid=%b f=%h ready_out=%b, required 1 %h 0", k, valid_s, f_s, ready_s, e.f_s);
            end
        end
        ready_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        e = sb.pop_front();
        vectors++;
        if (valid_s !== 1'b1 || f_s !== e.f_s || z_s !== (e.f_s == 16'h0) || n_s !== e.f_s[15] || v_s !== e.v_s || f_w !== e.f_w) begin
            miscompares++;
            $display("FAIL bp_queued: valid=%b f=%h z=%b n=%b v=%b, required 1 f=%h v=%b", valid_s, f_s, z_s, n_s, v_s, e.f_s, e.v_s);
        end
        @(posedge clk); #1;
        vectors++;
        if (valid_s !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drain: valid=%b, required 0", valid_s);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]   fs_t[6] = '{4'd1, 4'd3, 4'd7, 4'd4, 4'd10, 4'd6};
        logic [W-1:0] a_t[6]  = '{16'h0001, 16'h7FFF, 16'h0F00, 16'h0000, 16'h5555, 16'hFFFF};
        logic [W-1:0] b_t[6]  = '{16'h0000, 16'h0001, 16'h00F0, 16'h0001, 16'h0000, 16'h8421};
        int prev;
        exp_t e;
        ready_in = 1'b1;
        prev = cyc;
        for (int i = 0; i < 6; i++) begin
            send(fs_t[i], a_t[i], b_t[i]);
            vectors++;
            if (i > 0 && cyc - prev != 1) begin
                miscompares++;
                $display("FAIL b2b_rate op %0d: %0d cycles since previous accept, required 1", i, cyc - prev);
            end
            prev = cyc;
            e = sb.pop_front();
            vectors++;
            if (valid_s !== 1'b1 || f_s !== e.f_s || z_s !== (e.f_s == 16'h0) || n_s !== e.f_s[15] || v_s !== e.v_s) begin
                miscompares++;
                $display("FAIL b2b_sat fs=%0d a=%h b=%h: valid=%b f=%h z=%b n=%b v=%b, required 1 f=%h v=%b",
                         e.fs, e.a, e.b, valid_s, f_s, z_s, n_s, v_s, e.f_s, e.v_s);
            end
            vectors++;
            if (valid_w !== 1'b1 || f_w !== e.f_w || v_w !== e.v_w) begin
                miscompares++;
                $display("FAIL b2b_wrap fs=%0d: valid=%b f=%h v=%b, required 1 f=%h v=%b", e.fs, valid_w, f_w, v_w, e.f_w, e.v_w);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_mul;
        int lat, rdy_hi, seen;
        exp_t e;
        send(4'd13, 16'h0012, 16'h0034);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        vectors++;
        if (valid_s !== 1'b0 || f_s !== 16'h0 || ready_s !== 1'b1) begin
            miscompares++;
            $display("FAIL mulrst_async: valid=%b f=%h ready_out=%b, required 0 0000 1", valid_s, f_s, ready_s);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 2 * W; k++) begin
            @(posedge clk); #1;
            if (valid_s !== 1'b0 || ready_s !== 1'b1) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL mulrst_idle: %0d cycles with valid=1 or ready_out=0, required 0", seen);
        end
        send(4'd0, 16'h0000, 16'hBEEF);
        wait_valid(lat, rdy_hi);
        e = sb.pop_front();
        vectors++;
        if (lat != 1 || f_s !== e.f_s || z_s !== 1'b1 || n_s !== 1'b0 || v_s !== 1'b0) begin
            miscompares++;
            $display("FAIL mulrst_mova: latency %0d f=%h z=%b n=%b v=%b, required 1 f=%h z=1 n=0 v=0", lat, f_s, z_s, n_s, v_s, e.f_s);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_arith();
        test_fmul();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
